// File: rtl/rgb_to_ycbcr422.sv
// RGB888 to BT.601 limited-range YCbCr 4:2:2 converter, fixed 4-cycle latency.
// Chroma of each pixel pair is either averaged (CHROMA_AVG=1) or taken from the even pixel.
module rgb_to_ycbcr422 #(
    parameter bit CHROMA_AVG = 1'b1
) (
    input  logic        clk_pixel,
    input  logic        rst_n,
    input  logic [7:0]  rgb_r,
    input  logic [7:0]  rgb_g,
    input  logic [7:0]  rgb_b,
    input  logic        de_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    output logic [15:0] ycbcr_data,
    output logic        data_enable,
    output logic        hsync,
    output logic        vsync
);

    function automatic logic [7:0] clamp8(input logic signed [17:0] v,
                                          input logic [7:0] lo,
                                          input logic [7:0] hi);
        logic signed [17:0] s_lo;
        logic signed [17:0] s_hi;
        s_lo = $signed({10'd0, lo});
        s_hi = $signed({10'd0, hi});
        if (v < s_lo)
            return lo;
        else if (v > s_hi)
            return hi;
        else
            return v[7:0];
    endfunction

    logic signed [17:0] w_r, w_g, w_b;
    logic signed [17:0] w_y_sum, w_cb_sum, w_cr_sum;

    assign w_r = $signed({10'd0, rgb_r});
    assign w_g = $signed({10'd0, rgb_g});
    assign w_b = $signed({10'd0, rgb_b});

    assign w_y_sum  = 18'sd66 * w_r + 18'sd129 * w_g + 18'sd25 * w_b + 18'sd128;
    assign w_cb_sum = 18'sd112 * w_b - 18'sd38 * w_r - 18'sd74 * w_g + 18'sd128;
    assign w_cr_sum = 18'sd112 * w_r - 18'sd94 * w_g - 18'sd18 * w_b + 18'sd128;

    // S1: weighted sums
    logic signed [17:0] r1_y_sum, r1_cb_sum, r1_cr_sum;
    logic               r1_de, r1_hs, r1_vs, r1_vld;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r1_y_sum  <= '0;
            r1_cb_sum <= '0;
            r1_cr_sum <= '0;
            r1_de     <= 1'b0;
            r1_hs     <= 1'b0;
            r1_vs     <= 1'b0;
            r1_vld    <= 1'b0;
        end else begin
            r1_y_sum  <= w_y_sum;
            r1_cb_sum <= w_cb_sum;
            r1_cr_sum <= w_cr_sum;
            r1_de     <= de_in;
            r1_hs     <= hsync_in;
            r1_vs     <= vsync_in;
            r1_vld    <= 1'b1;
        end
    end

    // S2: floor shift, offset, clamp
    logic [7:0] w_y2, w_cb2, w_cr2;
    logic [7:0] r2_y, r2_cb, r2_cr;
    logic       r2_de, r2_hs, r2_vs, r2_vld;

    assign w_y2  = clamp8((r1_y_sum  >>> 8) + 18'sd16,  8'd16, 8'd235);
    assign w_cb2 = clamp8((r1_cb_sum >>> 8) + 18'sd128, 8'd16, 8'd240);
    assign w_cr2 = clamp8((r1_cr_sum >>> 8) + 18'sd128, 8'd16, 8'd240);

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r2_y   <= '0;
            r2_cb  <= '0;
            r2_cr  <= '0;
            r2_de  <= 1'b0;
            r2_hs  <= 1'b0;
            r2_vs  <= 1'b0;
            r2_vld <= 1'b0;
        end else begin
            r2_y   <= w_y2;
            r2_cb  <= w_cb2;
            r2_cr  <= w_cr2;
            r2_de  <= r1_de;
            r2_hs  <= r1_hs;
            r2_vs  <= r1_vs;
            r2_vld <= r1_vld;
        end
    end

    // S3: pair register; a pixel entering right after blanking is always even
    logic [7:0] r3_y, r3_cb, r3_cr;
    logic       r3_de, r3_odd, r3_hs, r3_vs, r3_vld;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r3_y   <= '0;
            r3_cb  <= '0;
            r3_cr  <= '0;
            r3_de  <= 1'b0;
            r3_odd <= 1'b0;
            r3_hs  <= 1'b0;
            r3_vs  <= 1'b0;
            r3_vld <= 1'b0;
        end else begin
            r3_y   <= r2_y;
            r3_cb  <= r2_cb;
            r3_cr  <= r2_cr;
            r3_de  <= r2_de;
            r3_odd <= r2_de & r3_de & ~r3_odd;
            r3_hs  <= r2_hs;
            r3_vs  <= r2_vs;
            r3_vld <= r2_vld;
        end
    end

    // S4: even pixel at S3 pairs with the odd pixel directly behind it at S2
    logic       w_pair, w_use_avg;
    logic [7:0] w_cb_mean, w_cr_mean, w_even_c;
    logic [7:0] r_cr_hold;

    assign w_pair    = r3_de & ~r3_odd & r2_de;
    assign w_use_avg = CHROMA_AVG & w_pair;
    assign w_cb_mean = 8'((9'(r3_cb) + 9'(r2_cb) + 9'd1) >> 1);
    assign w_cr_mean = 8'((9'(r3_cr) + 9'(r2_cr) + 9'd1) >> 1);
    assign w_even_c  = w_use_avg ? w_cb_mean : r3_cb;

    always_ff @(posedge clk_pixel or negedge rst_n) begin
        if (!rst_n) begin
            r_cr_hold   <= '0;
            ycbcr_data  <= '0;
            data_enable <= 1'b0;
            hsync       <= 1'b0;
            vsync       <= 1'b0;
        end else begin
            if (r3_de && !r3_odd)
                r_cr_hold <= w_use_avg ? w_cr_mean : r3_cr;
            if (r3_vld) begin
                if (!r3_de)
                    ycbcr_data <= 16'h1080;
                else
                    ycbcr_data <= {r3_y, (r3_odd ? r_cr_hold : w_even_c)};
            end
            data_enable <= r3_de;
            hsync       <= r3_hs;
            vsync       <= r3_vs;
        end
    end

endmodule

// File: tb/tb_rgb_to_ycbcr422.sv
// Bench for rgb_to_ycbcr422: averaging and decimating instances side by side,
// checked every cycle against a stream-level reference model plus fixed vectors.
module tb_rgb_to_ycbcr422;

    logic        clk_pixel = 1'b0;
    logic        rst_n;
    logic [7:0]  rgb_r, rgb_g, rgb_b;
    logic        de_in, hsync_in, vsync_in;
    logic [15:0] a_data, d_data;
    logic        a_de, a_hs, a_vs, d_de, d_hs, d_vs;

    always #5 clk_pixel = ~clk_pixel;

    rgb_to_ycbcr422 #(.CHROMA_AVG(1'b1)) u_avg (
        .clk_pixel(clk_pixel), .rst_n(rst_n),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .ycbcr_data(a_data), .data_enable(a_de), .hsync(a_hs), .vsync(a_vs)
    );

    rgb_to_ycbcr422 #(.CHROMA_AVG(1'b0)) u_dec (
        .clk_pixel(clk_pixel), .rst_n(rst_n),
        .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .de_in(de_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .ycbcr_data(d_data), .data_enable(d_de), .hsync(d_hs), .vsync(d_vs)
    );

    typedef struct {
        logic [7:0] r, g, b;
        logic       de, hs, vs;
    } px_t;

    typedef struct {
        logic [7:0]  r0, g0, b0, r1, g1, b1;
        logic [15:0] ev, od;
    } vec_t;

    px_t         hist[$];
    logic [15:0] cap[$];
    vec_t        vecs[5];
    int          checks = 0;
    int          failures = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : ((v > hi) ? hi : v);
    endfunction

    function automatic void conv(input px_t p, output int y, output int cb, output int cr);
        int r, g, b;
        r  = int'(p.r);
        g  = int'(p.g);
        b  = int'(p.b);
        y  = clampi(16 + ((66 * r + 129 * g + 25 * b + 128) >>> 8), 16, 235);
        cb = clampi(128 + ((-38 * r - 74 * g + 112 * b + 128) >>> 8), 16, 240);
        cr = clampi(128 + ((112 * r - 94 * g - 18 * b + 128) >>> 8), 16, 240);
    endfunction

    // Output now corresponds to the input pushed four cycles ago.
    function automatic void model(input bit avg, output logic [15:0] d,
                                  output logic de, output logic hs, output logic vs);
        int n, k, pos, y, cb, cr, y2, cb2, cr2, c;
        n = hist.size();
        d = 16'h0000; de = 1'b0; hs = 1'b0; vs = 1'b0;
        if (n >= 4) begin
            k  = n - 4;
            de = hist[k].de;
            hs = hist[k].hs;
            vs = hist[k].vs;
            if (!hist[k].de) begin
                d = 16'h1080;
            end else begin
                pos = 0;
                for (int j = k - 1; j >= 0 && hist[j].de; j--)
                    pos++;
                conv(hist[k], y, cb, cr);
                if (pos % 2 == 0) begin
                    c = cb;
                    if (avg && hist[k + 1].de) begin
                        conv(hist[k + 1], y2, cb2, cr2);
                        c = (cb + cb2 + 1) / 2;
                    end
                end else begin
                    conv(hist[k - 1], y2, cb2, cr2);
                    c = avg ? (cr2 + cr + 1) / 2 : cr2;
                end
                d = {y[7:0], c[7:0]};
            end
        end
    endfunction

    task automatic check_outputs();
        logic [15:0] ed;
        logic        ede, ehs, evs;
        model(1'b1, ed, ede, ehs, evs);
        chk("avg_data", a_data, ed);
        chk("avg_de", 16'(a_de), 16'(ede));
        chk("avg_hsync", 16'(a_hs), 16'(ehs));
        chk("avg_vsync", 16'(a_vs), 16'(evs));
        model(1'b0, ed, ede, ehs, evs);
        chk("dec_data", d_data, ed);
        chk("dec_de", 16'(d_de), 16'(ede));
        chk("dec_hsync", 16'(d_hs), 16'(ehs));
        chk("dec_vsync", 16'(d_vs), 16'(evs));
        if (a_de)
            cap.push_back(a_data);
    endtask

    task automatic step(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                        input logic de, input logic hs, input logic vs);
        px_t p;
        check_outputs();
        rgb_r = r; rgb_g = g; rgb_b = b;
        de_in = de; hsync_in = hs; vsync_in = vs;
        p.r = r; p.g = g; p.b = b; p.de = de; p.hs = hs; p.vs = vs;
        if (rst_n)
            hist.push_back(p);
        @(negedge clk_pixel);
    endtask

    task automatic pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        step(r, g, b, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            step(8'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic rand_pix();
        pix(8'($urandom), 8'($urandom), 8'($urandom));
    endtask

    initial begin
        vecs[0] = '{8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 8'd255, 16'hEB80, 16'hEB80};
        vecs[1] = '{8'd255, 8'd0,   8'd0,   8'd255, 8'd0,   8'd0,   16'h525A, 16'h52F0};
        vecs[2] = '{8'd0,   8'd0,   8'd0,   8'd255, 8'd255, 8'd255, 16'h1080, 16'hEB80};
        vecs[3] = '{8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd255, 16'h10B8, 16'h2977};
        vecs[4] = '{8'd0,   8'd255, 8'd0,   8'd0,   8'd255, 8'd0,   16'h9036, 16'h9022};

        rst_n = 1'b0;
        rgb_r = '0; rgb_g = '0; rgb_b = '0;
        de_in = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
        @(negedge clk_pixel);
        idle(3);
        rst_n = 1'b1;
        idle(6);

        // constant white line
        cap.delete();
        for (int i = 0; i < 8; i++)
            pix(8'd255, 8'd255, 8'd255);
        idle(6);
        chk("white_count", 16'(cap.size()), 16'd8);
        foreach (cap[i])
            chk($sformatf("white_word%0d", i), cap[i], 16'hEB80);

        // pure red, Cb first then alternating
        cap.delete();
        for (int i = 0; i < 6; i++)
            pix(8'd255, 8'd0, 8'd0);
        idle(6);
        chk("red_count", 16'(cap.size()), 16'd6);
        foreach (cap[i])
            chk($sformatf("red_word%0d", i), cap[i], (i % 2 == 0) ? 16'h525A : 16'h52F0);

        // two-pixel lines from the vector table
        for (int v = 0; v < 5; v++) begin
            cap.delete();
            pix(vecs[v].r0, vecs[v].g0, vecs[v].b0);
            pix(vecs[v].r1, vecs[v].g1, vecs[v].b1);
            idle(5);
            chk($sformatf("vec%0d_count", v), 16'(cap.size()), 16'd2);
            if (cap.size() >= 2) begin
                chk($sformatf("vec%0d_even", v), cap[0], vecs[v].ev);
                chk($sformatf("vec%0d_odd", v), cap[1], vecs[v].od);
            end
        end

        // odd-length line, 1-cycle gap, new line; then single-pixel pulses
        for (int i = 0; i < 3; i++) rand_pix();
        idle(1);
        for (int i = 0; i < 4; i++) rand_pix();
        idle(1);
        for (int i = 0; i < 6; i++) begin
            rand_pix();
            idle(1);
        end
        idle(5);

        // sync-only traffic in blanking
        for (int i = 0; i < 40; i++)
            step(8'($urandom), 8'($urandom), 8'($urandom), 1'b0,
                 1'($urandom), 1'($urandom));
        idle(5);

        // random lines with random gaps and syncs
        for (int i = 0; i < 500; i++)
            step(8'($urandom), 8'($urandom), 8'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom));
        idle(5);

        // asynchronous reset mid-line
        for (int i = 0; i < 3; i++) rand_pix();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_avg_data", a_data, 16'h0000);
        chk("rst_avg_de", 16'(a_de), 16'd0);
        chk("rst_avg_hsync", 16'(a_hs), 16'd0);
        chk("rst_avg_vsync", 16'(a_vs), 16'd0);
        chk("rst_dec_data", d_data, 16'h0000);
        chk("rst_dec_de", 16'(d_de), 16'd0);
        hist.delete();
        @(negedge clk_pixel);
        rst_n = 1'b1;
        cap.delete();
        pix(8'd255, 8'd0, 8'd0);
        pix(8'd255, 8'd0, 8'd0);
        pix(8'd255, 8'd0, 8'd0);
        idle(6);
        chk("post_rst_count", 16'(cap.size()), 16'd3);
        if (cap.size() >= 1)
            chk("post_rst_first_cb", cap[0], 16'h525A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
